// File: rtl/fdc_pkg.sv
// Shared constants for the fdc decimation chain: half-band taps, rounding and
// accumulator sizing.
package fdc_pkg;

   localparam int unsigned NTAPS     = 5;
   localparam int unsigned COEF_W    = 11;
   localparam int unsigned ACC_XTRA  = 14;  // accumulator width is BW + ACC_XTRA
   localparam int          RND_ADD   = 1024;
   localparam int unsigned RND_SHIFT = 11;

   localparam logic signed [COEF_W-1:0] COEF [NTAPS] = '{
      11'sd211, 11'sd420, 11'sd503, 11'sd420, 11'sd211
   };

endpackage

// File: rtl/fdc_hb_stage.sv
// One decimate-by-2 half-band stage: 5-tap window per channel, result emitted on
// every second accepted sample.
module fdc_hb_stage
   import fdc_pkg::*;
#(
   parameter int unsigned BW = 12
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 flush,
   input  logic                 vld_in,
   input  logic signed [BW-1:0] i_in,
   input  logic signed [BW-1:0] q_in,
   output logic                 vld_out,
   output logic signed [BW-1:0] i_out,
   output logic signed [BW-1:0] q_out,
   output logic                 vld_nxt,
   output logic signed [BW-1:0] i_nxt,
   output logic signed [BW-1:0] q_nxt
);

   localparam int unsigned AW = BW + ACC_XTRA;
   localparam logic signed [AW-1:0] MAXV = AW'((2 ** (BW - 1)) - 1);
   localparam logic signed [AW-1:0] MINV = AW'(-(2 ** (BW - 1)));

   // History holds x[n-1..n-4]; x[n] is the sample arriving this cycle.
   logic signed [BW-1:0] hi_q [NTAPS-1];
   logic signed [BW-1:0] hq_q [NTAPS-1];
   logic signed [BW-1:0] wi   [NTAPS];
   logic signed [BW-1:0] wq   [NTAPS];
   logic signed [AW-1:0] acc_i, acc_q;
   logic                 phase_q, vld_q;
   logic signed [BW-1:0] yi_q, yq_q;

   function automatic logic signed [BW-1:0] rnd_sat(input logic signed [AW-1:0] acc);
      logic signed [AW-1:0] r;
      r = (acc + AW'(RND_ADD)) >>> RND_SHIFT;
      if (r > MAXV) return MAXV[BW-1:0];
      if (r < MINV) return MINV[BW-1:0];
      return r[BW-1:0];
   endfunction

   always_comb begin
      wi[0] = i_in;
      wq[0] = q_in;
      for (int t = 1; t < NTAPS; t++) begin
         wi[t] = hi_q[t-1];
         wq[t] = hq_q[t-1];
      end
      acc_i = '0;
      acc_q = '0;
      for (int t = 0; t < NTAPS; t++) begin
         acc_i = acc_i + AW'(COEF[t]) * AW'(wi[t]);
         acc_q = acc_q + AW'(COEF[t]) * AW'(wq[t]);
      end
      vld_nxt = vld_in && phase_q && !flush;
      i_nxt   = rnd_sat(acc_i);
      q_nxt   = rnd_sat(acc_q);
   end

   always_ff @(posedge clk) begin
      if (!rstb || flush) begin
         phase_q <= 1'b0;
         vld_q   <= 1'b0;
         yi_q    <= '0;
         yq_q    <= '0;
         for (int t = 0; t < NTAPS - 1; t++) begin
            hi_q[t] <= '0;
            hq_q[t] <= '0;
         end
      end else begin
         vld_q <= vld_nxt;
         if (vld_in) begin
            phase_q <= ~phase_q;
            hi_q[0] <= i_in;
            hq_q[0] <= q_in;
            for (int t = 1; t < NTAPS - 1; t++) begin
               hi_q[t] <= hi_q[t-1];
               hq_q[t] <= hq_q[t-1];
            end
         end
         if (vld_nxt) begin
            yi_q <= i_nxt;
            yq_q <= q_nxt;
         end
      end
   end

   always_comb begin
      vld_out = vld_q;
      i_out   = yi_q;
      q_out   = yq_q;
   end

endmodule

// File: rtl/fdc_decim_chain.sv
// Cascade of NSTAGES half-band decimators; dec_sel picks the tap point and a
// change of dec_sel flushes every stage.
module fdc_decim_chain
   import fdc_pkg::*;
#(
   parameter int unsigned BW      = 12,
   parameter int unsigned NSTAGES = 3
) (
   input  logic                               clk,
   input  logic                               rstb,
   input  logic                               in_valid,
   input  logic signed [BW-1:0]               Iin,
   input  logic signed [BW-1:0]               Qin,
   input  logic [$clog2(NSTAGES + 1) - 1:0]   dec_sel,
   output logic                               out_valid,
   output logic signed [BW-1:0]               Iout,
   output logic signed [BW-1:0]               Qout
);

   localparam int unsigned SW = $clog2(NSTAGES + 1);

   logic [SW-1:0]        sel_in, sel_q;
   logic                 flush_q, chg, tap_vld;
   logic                 s0_vld_q;
   logic signed [BW-1:0] s0_i_q, s0_q_q;

   // Index 0 is the input register; index k is half-band stage k.
   logic                 vld_r [NSTAGES+1];
   logic signed [BW-1:0] i_r   [NSTAGES+1];
   logic signed [BW-1:0] q_r   [NSTAGES+1];
   logic                 vld_n [NSTAGES+1];
   logic signed [BW-1:0] i_n   [NSTAGES+1];
   logic signed [BW-1:0] q_n   [NSTAGES+1];

   logic                 out_valid_q;
   logic signed [BW-1:0] iout_q, qout_q;

   always_comb begin
      sel_in = (32'(dec_sel) > NSTAGES) ? SW'(NSTAGES) : dec_sel;
      chg    = (sel_in != sel_q);
   end

   assign vld_n[0] = in_valid && !flush_q;
   assign i_n[0]   = Iin;
   assign q_n[0]   = Qin;
   assign vld_r[0] = s0_vld_q;
   assign i_r[0]   = s0_i_q;
   assign q_r[0]   = s0_q_q;

   always_ff @(posedge clk) begin
      if (!rstb) begin
         sel_q    <= sel_in;
         flush_q  <= 1'b0;
         s0_vld_q <= 1'b0;
         s0_i_q   <= '0;
         s0_q_q   <= '0;
      end else begin
         sel_q    <= sel_in;
         flush_q  <= chg;
         s0_vld_q <= vld_n[0];
         if (vld_n[0]) begin
            s0_i_q <= Iin;
            s0_q_q <= Qin;
         end
      end
   end

   for (genvar k = 1; k <= NSTAGES; k++) begin : g_stage
      logic                 v_o, v_n;
      logic signed [BW-1:0] io, qo, inx, qnx;

      fdc_hb_stage #(
         .BW (BW)
      ) u_stage (
         .clk     (clk),
         .rstb    (rstb),
         .flush   (flush_q),
         .vld_in  (vld_r[k-1]),
         .i_in    (i_r[k-1]),
         .q_in    (q_r[k-1]),
         .vld_out (v_o),
         .i_out   (io),
         .q_out   (qo),
         .vld_nxt (v_n),
         .i_nxt   (inx),
         .q_nxt   (qnx)
      );

      assign vld_r[k] = v_o;
      assign i_r[k]   = io;
      assign q_r[k]   = qo;
      assign vld_n[k] = v_n;
      assign i_n[k]   = inx;
      assign q_n[k]   = qnx;
   end

   // Output register samples the selected stage's next state, so it lines up
   // with that stage's own register; a pending dec_sel change suppresses it.
   always_comb begin
      tap_vld = vld_n[sel_q] && !flush_q && !chg;
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         out_valid_q <= 1'b0;
         iout_q      <= '0;
         qout_q      <= '0;
      end else begin
         out_valid_q <= tap_vld;
         if (tap_vld) begin
            iout_q <= i_n[sel_q];
            qout_q <= q_n[sel_q];
         end
      end
   end

   always_comb begin
      out_valid = out_valid_q;
      Iout      = iout_q;
      Qout      = qout_q;
   end

endmodule

// File: tb/tb_fdc_decim_chain.sv
// Directed and randomized checks of fdc_decim_chain against an arithmetic
// model of the cascaded 5-tap decimators.
module tb_fdc_decim_chain;

   localparam int BW  = 12;
   localparam int NST = 3;
   localparam int MAXS = (2 ** (BW - 1)) - 1;
   localparam int MINS = -(2 ** (BW - 1));
   localparam int COEFS [5] = '{211, 420, 503, 420, 211};

   logic                 clk = 1'b0;
   logic                 rstb;
   logic                 in_valid;
   logic signed [BW-1:0] Iin, Qin;
   logic [1:0]           dec_sel;
   logic                 out_valid;
   logic signed [BW-1:0] Iout, Qout;

   fdc_decim_chain #(
      .BW      (BW),
      .NSTAGES (NST)
   ) dut (
      .clk       (clk),
      .rstb      (rstb),
      .in_valid  (in_valid),
      .Iin       (Iin),
      .Qin       (Qin),
      .dec_sel   (dec_sel),
      .out_valid (out_valid),
      .Iout      (Iout),
      .Qout      (Qout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int i;
      int q;
      int due;
   } exp_t;

   int   xi [0:NST][0:4095];
   int   xq [0:NST][0:4095];
   int   xn [0:NST];
   exp_t expq [$];
   int   obs_i [$];
   int   cyc, total, bad, dsel, last_i, last_q;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp_v);
      total++;
      assert (obs === exp_v)
      else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp_v, cyc);
      end
   endtask

   function automatic int fir_out(input int lvl, input bit qch);
      int s = 0;
      int n = xn[lvl] - 1;
      int r;
      for (int t = 0; t < 5; t++)
         if (n - t >= 0) s += COEFS[t] * (qch ? xq[lvl][n-t] : xi[lvl][n-t]);
      r = (s + 1024) >>> 11;
      if (r > MAXS) r = MAXS;
      if (r < MINS) r = MINS;
      return r;
   endfunction

   // Push one input sample; every second sample at a level yields one sample
   // at the next level, until the selected level is reached.
   task automatic model_push(input int vi, input int vq, input int edge_n);
      int   lvl = 0;
      int   a = vi;
      int   b = vq;
      bit   done = 1'b0;
      exp_t e;
      while (!done) begin
         xi[lvl][xn[lvl]] = a;
         xq[lvl][xn[lvl]] = b;
         xn[lvl]++;
         if (lvl == dsel) begin
            e.i = a; e.q = b; e.due = edge_n + dsel;
            expq.push_back(e);
            done = 1'b1;
         end else if (xn[lvl] % 2 != 0) begin
            done = 1'b1;
         end else begin
            a = fir_out(lvl, 1'b0);
            b = fir_out(lvl, 1'b1);
            lvl++;
         end
      end
   endtask

   task automatic model_reset(input bit hard);
      for (int l = 0; l <= NST; l++) xn[l] = 0;
      expq.delete();
      obs_i.delete();
      if (hard) begin
         last_i = 0;
         last_q = 0;
      end
   endtask

   task automatic monitor();
      logic signed [31:0] oi, oq;
      exp_t e;
      bit   due;
      oi = Iout;
      oq = Qout;
      if (out_valid === 1'b1) begin
         obs_i.push_back(oi);
         check("valid_was_expected", (expq.size() > 0) ? 1 : 0, 1);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("valid_cycle", cyc, e.due);
            check("Iout", oi, e.i);
            check("Qout", oq, e.q);
         end
         last_i = oi;
         last_q = oq;
      end else begin
         due = (expq.size() > 0) && (expq[0].due <= cyc);
         check("out_valid", {31'b0, out_valid}, due ? 1 : 0);
         if (due) void'(expq.pop_front());
         check("Iout_hold", oi, last_i);
         check("Qout_hold", oq, last_q);
      end
   endtask

   task automatic step(input bit v, input int vi, input int vq, input bit keep);
      in_valid = v;
      Iin      = BW'(vi);
      Qin      = BW'(vq);
      if (!rstb) model_reset(1'b1);
      else if (v && keep) model_push(vi, vq, cyc + 1);
      @(posedge clk);
      cyc++;
      #1;
      monitor();
   endtask

   task automatic do_reset(input int sel);
      rstb    = 1'b0;
      dec_sel = 2'(sel);
      dsel    = (sel > NST) ? NST : sel;
      step(1'b0, 0, 0, 1'b0);
      check("rst_out_valid", {31'b0, out_valid}, 0);
      check("rst_Iout", Iout, 0);
      check("rst_Qout", Qout, 0);
      rstb = 1'b1;
   endtask

   function automatic int rnd_sample();
      return int'($urandom_range(0, 4095)) - 2048;
   endfunction

   initial begin
      bit v;
      cyc = 0; total = 0; bad = 0; last_i = 0; last_q = 0;
      rstb = 1'b0; in_valid = 1'b0; Iin = '0; Qin = '0; dec_sel = 2'd1; dsel = 1;
      model_reset(1'b1);
      do_reset(1);
      do_reset(1);

      // DC through one stage
      repeat (40) step(1'b1, 1000, 1000, 1'b1);
      check("dc1_I", last_i, 862);
      check("dc1_Q", last_q, 862);

      // DC through two stages on Q only
      do_reset(2);
      repeat (64) step(1'b1, 0, 1000, 1'b1);
      check("dc2_Q", last_q, 743);
      check("dc2_I", last_i, 0);

      // Impulse response
      do_reset(1);
      step(1'b1, 2047, 0, 1'b1);
      repeat (9) step(1'b1, 0, 0, 1'b1);
      repeat (4) step(1'b0, 0, 0, 1'b1);
      check("imp_count", obs_i.size(), 5);
      if (obs_i.size() >= 3) begin
         check("imp_0", obs_i[0], 420);
         check("imp_1", obs_i[1], 420);
         check("imp_2", obs_i[2], 0);
      end

      // Negative full scale
      do_reset(1);
      repeat (30) step(1'b1, -2048, -2048, 1'b1);
      check("negfs_I", last_i, -1765);
      check("negfs_Q", last_q, -1765);

      // Random data, sparse valid, every tap point
      for (int s = 0; s <= NST; s++) begin
         do_reset(s);
         for (int j = 0; j < 150; j++) begin
            v = 1'($urandom_range(0, 1));
            step(v, rnd_sample(), rnd_sample(), 1'b1);
         end
         repeat (8) step(1'b0, 0, 0, 1'b1);
      end

      // Flush on dec_sel change 1 -> 2
      do_reset(1);
      repeat (21) step(1'b1, rnd_sample(), rnd_sample(), 1'b1);
      repeat (6) step(1'b0, 0, 0, 1'b1);
      dec_sel = 2'd2;
      dsel    = 2;
      step(1'b0, 0, 0, 1'b1);
      check("flush_out_valid", {31'b0, out_valid}, 0);
      model_reset(1'b0);
      step(1'b1, 1500, -1500, 1'b0);
      repeat (3) step(1'b1, rnd_sample(), rnd_sample(), 1'b1);
      repeat (2) step(1'b0, 0, 0, 1'b1);
      check("flush_no_early_out", obs_i.size(), 0);
      step(1'b1, rnd_sample(), rnd_sample(), 1'b1);
      repeat (4) step(1'b0, 0, 0, 1'b1);
      check("flush_first_out", obs_i.size(), 1);

      // Reset pulse mid-stream with 1-in-3 valid
      do_reset(1);
      for (int j = 0; j < 60; j++) step(j % 3 == 0, rnd_sample(), rnd_sample(), 1'b1);
      rstb = 1'b0;
      step(1'b1, 777, 777, 1'b1);
      check("midrst_out_valid", {31'b0, out_valid}, 0);
      check("midrst_Iout", Iout, 0);
      check("midrst_Qout", Qout, 0);
      rstb = 1'b1;
      for (int j = 0; j < 60; j++) step(j % 3 == 0, rnd_sample(), rnd_sample(), 1'b1);
      repeat (8) step(1'b0, 0, 0, 1'b1);

      check("nothing_pending", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
